// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory: funct3 codes, latency
// bounds, access size decode and the response payload layout.
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Response carried down the pipe to writeback.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              we_reg;
    logic [RD_W-1:0]   rd;
    logic              misalign;
  } resp_t;

  // Access size from funct3; every code that is not b/h/bu/hu acts as a word.
  function automatic size_e f3_size(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU)      return SZ_B;
    else if (f3 == F3_H || f3 == F3_HU) return SZ_H;
    else                                return SZ_W;
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction
endpackage

// File: rtl/dmem_pipe_stage.sv
// One valid+payload register of the response pipe. Shifts when the global
// advance is high, clears synchronously on reset.
module dmem_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  // Stage register: hold on stall, take upstream contents on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end
endmodule

// File: rtl/pipelined_data_mem.sv
// Data memory for the MEM stage: byte/half/word stores and loads with sign or
// zero extension, LATENCY-cycle response pipe with valid/ready backpressure,
// and rd/reg-write tag carried through to writeback.
// Build option: DMEM_MISALIGN_TRAP_EN flags misaligned requests on out_misalign
// and suppresses their effect; without it low address bits are forced to
// natural alignment.
module pipelined_data_mem
  import dmem_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 14,
  parameter int    ADDR_W     = 32,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic              in_we,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_we_reg,
  output logic [4:0]        out_rd
`ifdef DMEM_MISALIGN_TRAP_EN
  , output logic            out_misalign
`endif
);
  localparam int WORDS = 2 ** DEPTH_LOG2;
  localparam int PW    = $bits(resp_t);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("pipelined_data_mem: LATENCY must be within 1..4");
  end

  logic [31:0] mem [WORDS];

  logic                  advance, accept, req_trap;
  size_e                 req_size;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [31:0]           wd;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  unused_addr;

  assign advance   = out_ready || !out_valid;
  assign in_ready  = advance && !RST;
  assign accept    = in_valid && in_ready;
  assign req_size  = f3_size(in_funct3);
  assign widx      = in_addr[DEPTH_LOG2+1:2];
  // Upper address bits alias onto the array.
  assign unused_addr = ^in_addr[ADDR_W-1:DEPTH_LOG2+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic req_mis;
  // Natural-alignment test for the incoming request.
  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      SZ_H:    req_mis = in_addr[0];
      SZ_W:    req_mis = |in_addr[1:0];
      default: req_mis = 1'b0;
    endcase
  end
  assign req_trap = req_mis;
`else
  assign req_trap = 1'b0;
`endif

  // Lane within the word, forced to natural alignment; identical to the raw
  // address bits for aligned requests.
  always_comb begin
    lane = in_addr[1:0];
    case (req_size)
      SZ_B:    lane = in_addr[1:0];
      SZ_H:    lane = {in_addr[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be = 4'b0000;
    wd = in_wdata;
    case (req_size)
      SZ_B: begin
        be[lane] = 1'b1;
        wd       = {4{in_wdata[7:0]}};
      end
      SZ_H: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{in_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Array write on the accept edge; accept is already blocked during reset.
  always_ff @(posedge CLK) begin
    if (accept && in_we && !req_trap) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  logic [31:0] rd_word;
  // Synchronous array read into stage 1, no reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (accept && !in_we) rd_word <= mem[widx];
  end

  logic       s1_valid, s1_load, s1_uns, s1_mis;
  logic [1:0] s1_lane;
  size_e      s1_size;
  logic [4:0] s1_rd;

  // Stage 1 control: request attributes captured alongside the array read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_load  <= 1'b0;
      s1_uns   <= 1'b0;
      s1_mis   <= 1'b0;
      s1_lane  <= 2'b00;
      s1_size  <= SZ_B;
      s1_rd    <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_load  <= !in_we;
      s1_uns   <= f3_unsigned(in_funct3);
      s1_mis   <= req_trap;
      s1_lane  <= lane;
      s1_size  <= req_size;
      s1_rd    <= in_rd;
    end
  end

  logic [31:0] shifted, ext;
  resp_t       resp0;

  // Lane extraction and extension; bubbles and stores present all-zero data.
  always_comb begin
    shifted = rd_word >> {s1_lane, 3'b000};
    ext     = rd_word;
    case (s1_size)
      SZ_B:    ext = s1_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      SZ_H:    ext = s1_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = rd_word;
    endcase
    resp0 = '0;
    if (s1_valid) begin
      resp0.rd       = s1_rd;
      resp0.misalign = s1_mis;
      if (s1_load && !s1_mis) begin
        resp0.data   = ext;
        resp0.we_reg = (s1_rd != 5'd0);
      end
    end
  end

  logic [LATENCY-1:0]         vld_pipe;
  logic [LATENCY-1:0][PW-1:0] pay_pipe;
  resp_t                      out_resp;

  assign vld_pipe[0] = s1_valid;
  assign pay_pipe[0] = resp0;

  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    dmem_pipe_stage #(.W(PW)) u_stage (
      .clk       (CLK),
      .rst       (RST),
      .advance   (advance),
      .in_valid  (vld_pipe[i-1]),
      .in_data   (pay_pipe[i-1]),
      .out_valid (vld_pipe[i]),
      .out_data  (pay_pipe[i])
    );
  end

  assign out_resp   = pay_pipe[LATENCY-1];
  assign out_valid  = vld_pipe[LATENCY-1];
  assign out_data   = out_resp.data;
  assign out_we_reg = out_resp.we_reg;
  assign out_rd     = out_resp.rd;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign out_misalign = out_resp.misalign;
`else
  logic unused_mis;
  assign unused_mis = out_resp.misalign;
`endif
endmodule

// File: tb/tb_pipelined_data_mem.sv
// Scoreboard bench for pipelined_data_mem (LATENCY = 3): a byte-level memory
// model predicts each response at accept time; a monitor compares every
// presented response and pops on handshake.
module tb_pipelined_data_mem;
  localparam int LAT = 3;
  localparam int DL2 = 14;
  localparam int unsigned MASK = (32'd1 << (DL2 + 2)) - 1;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        in_valid = 1'b0, in_we = 1'b0, out_ready = 1'b1;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_ready, out_valid, out_we_reg;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        out_misalign;
`endif

  pipelined_data_mem #(.DEPTH_LOG2(DL2), .ADDR_W(32), .LATENCY(LAT), .INIT_FILE("")) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_we(in_we), .in_funct3(in_funct3), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_we_reg(out_we_reg), .out_rd(out_rd)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .out_misalign(out_misalign)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        we_reg;
    logic [4:0]  rd;
    logic        mis;
    int          acc_cyc;
    bit          exact;
  } exp_t;

  exp_t       sb_q[$];
  bit [7:0]   mem_m [int unsigned];
  int         n_checks = 0, n_fail = 0, cyc = 0;
  bit         manual = 1'b1, timed = 1'b0;

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: little-endian byte array, plain size/sign arithmetic.
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input logic [4:0] rd);
    exp_t        e;
    int          sz;
    bit          uns;
    logic [31:0] a, v;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    uns = f3[2] && (sz < 4);
    e.data = '0; e.we_reg = 1'b0; e.rd = rd; e.mis = 1'b0; e.acc_cyc = 0; e.exact = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((addr % sz) != 0) begin
      e.mis = 1'b1;
      return e;
    end
`endif
    a = addr - (addr % sz);
    if (we) begin
      for (int i = 0; i < sz; i++) mem_m[(a + i) & MASK] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_m[(a + i) & MASK];
      if (!uns && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!uns && sz == 2) v = {{16{v[15]}}, v[15:0]};
      e.data = v;
      e.we_reg = (rd != 5'd0);
    end
    return e;
  endfunction

  // Present one request (called at posedge+1), hold until accepted.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [4:0] rd);
    exp_t e;
    bit   acc = 1'b0;
    in_valid = 1'b1; in_we = we; in_addr = addr; in_wdata = wdata; in_funct3 = f3; in_rd = rd;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge CLK);
      if (in_ready) begin
        acc = 1'b1;
        e = model(we, addr, wdata, f3, rd);
        e.acc_cyc = cyc;
        e.exact = (sb_q.size() == 0);
        sb_q.push_back(e);
      end
      @(posedge CLK); #1;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: request at addr 0x%0h never accepted", addr);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge CLK);
    end
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Random backpressure when not under direct control.
  initial forever begin
    @(posedge CLK); #1;
    if (!manual) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare every presented response, pop on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("in_ready", 32'(in_ready), 32'(out_ready || !out_valid));
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL spurious_resp: out_valid with rd=%0d data=0x%0h, none expected", out_rd, out_data);
          end else begin
            e = sb_q[0];
            if (!timed) begin
              timed = 1'b1;
              if (e.exact) chk("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
              else         chk("latency_min", 32'((cyc - e.acc_cyc) >= LAT), 32'd1);
            end
            chk("data", out_data, e.data);
            chk("we_reg", 32'(out_we_reg), 32'(e.we_reg));
            chk("rd", 32'(out_rd), 32'(e.rd));
`ifdef DMEM_MISALIGN_TRAP_EN
            chk("misalign", 32'(out_misalign), 32'(e.mis));
`endif
            if (out_ready) begin
              void'(sb_q.pop_front());
              timed = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_we_reg"}, 32'(out_we_reg), 32'd0);
    chk({tag, "_out_rd"}, 32'(out_rd), 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk({tag, "_out_misalign"}, 32'(out_misalign), 32'd0);
`endif
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk_idle_outputs("rst");
    @(posedge CLK); #1 RST = 1'b0;
    @(posedge CLK); #1;

    // Preload the 16 words the bench uses.
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, F_W, 5'd0);

    // Sub-word loads of a known word.
    issue(1'b1, 32'h10, 32'hDEADBEEF, F_W, 5'd1);
    issue(1'b0, 32'h13, 32'h0, F_B, 5'd2);
    issue(1'b0, 32'h13, 32'h0, F_BU, 5'd3);
    issue(1'b0, 32'h12, 32'h0, F_H, 5'd4);
    issue(1'b0, 32'h10, 32'h0, F_HU, 5'd5);
    issue(1'b0, 32'h10, 32'h0, F_W, 5'd6);
    for (int i = 0; i < 4; i++) issue(1'b0, 32'h10 + 32'(i), 32'h0, F_B, 5'd8);

    // Byte store leaves other lanes untouched.
    issue(1'b1, 32'h20, 32'h0, F_W, 5'd0);
    issue(1'b1, 32'h21, 32'hAAAAAA55, F_B, 5'd0);
    issue(1'b0, 32'h20, 32'h0, F_W, 5'd9);
    issue(1'b1, 32'h26, 32'h1234CAFE, F_H, 5'd0);
    issue(1'b0, 32'h24, 32'h0, F_W, 5'd10);

    // Address wrap modulo the array size.
    issue(1'b1, 32'h4, 32'h12345678, F_W, 5'd0);
    issue(1'b0, 32'h4 + 32'(4 * (2 ** DL2)), 32'h0, F_W, 5'd11);

    // Misaligned word load.
    issue(1'b0, 32'h6, 32'h0, F_W, 5'd7);
    drain();

    // Back-to-back loads against a stalled consumer.
    out_ready = 1'b0;
    fork
      begin
        issue(1'b0, 32'h10, 32'h0, F_W, 5'd12);
        issue(1'b0, 32'h11, 32'h0, F_BU, 5'd13);
        issue(1'b0, 32'h12, 32'h0, F_H, 5'd14);
        issue(1'b0, 32'h20, 32'h0, F_W, 5'd15);
        issue(1'b0, 32'h13, 32'h0, F_B, 5'd16);
      end
      begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        @(posedge CLK); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two loads in flight and a store presented.
    out_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, F_W, 5'd3);
    issue(1'b0, 32'h12, 32'h0, F_H, 5'd4);
    in_valid = 1'b1; in_we = 1'b1; in_addr = 32'h20; in_wdata = 32'hFFFFFFFF; in_funct3 = F_W; in_rd = 5'd0;
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    sb_q.delete();
    timed = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge CLK);
    chk_idle_outputs("midrst");
    @(posedge CLK); #1;
    issue(1'b0, 32'h20, 32'h0, F_W, 5'd0);
    drain();

    // Randomized traffic with random backpressure and idle gaps.
    manual = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end else if ($urandom_range(0, 2) == 0)
        issue(1'b1, a, $urandom, 3'($urandom_range(0, 2)), 5'($urandom));
      else
        issue(1'b0, a, 32'h0, 3'($urandom), 5'($urandom));
    end
    manual = 1'b1;
    @(posedge CLK); #1 out_ready = 1'b1;
    drain();
    @(negedge CLK);
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
